// File: rtl/tow_param_if.sv
// tow_param_if: button inputs and display/score outputs of the tug-of-war core.
// master = board/button side, slave = the game core.
interface tow_param_if #(
    parameter int N_LEDS        = 7,
    parameter int ROUNDS_TO_WIN = 2
);
    localparam int SW = $clog2(ROUNDS_TO_WIN + 1);

    logic              pbl;
    logic              pbr;
    logic [N_LEDS-1:0] led_out;
    logic [SW-1:0]     score_l;
    logic [SW-1:0]     score_r;
    logic              match_over;

    modport master (output pbl, pbr, input led_out, score_l, score_r, match_over);
    modport slave  (input pbl, pbr, output led_out, score_l, score_r, match_over);
endinterface

// File: rtl/tow_param.sv
// tow_param: parameterised tug-of-war game core with best-of-rounds scoring.
// Optional macro TOW_SYNC_EN: each button passes a two-flop synchroniser
// before edge detection (two extra cycles of push latency).
module tow_param #(
    parameter int N_LEDS        = 7,
    parameter int WIN_LEDS      = 3,
    parameter int DARK_CYCLES   = 4,
    parameter int SHOW_CYCLES   = 8,
    parameter int ROUNDS_TO_WIN = 2
) (
    input  logic      clk,
    input  logic      rst,
    tow_param_if.slave bus
);
    localparam int SW   = $clog2(ROUNDS_TO_WIN + 1);
    localparam int PW   = $clog2(N_LEDS);
    localparam int MAXC = (DARK_CYCLES > SHOW_CYCLES) ? DARK_CYCLES : SHOW_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [PW-1:0]     CENTRE = PW'((N_LEDS - 1) / 2);
    localparam logic [PW-1:0]     TOP    = PW'(N_LEDS - 1);
    localparam logic [SW-1:0]     RMAX   = SW'(ROUNDS_TO_WIN);
    localparam logic [N_LEDS-1:0] ALL    = '1;
    localparam logic [N_LEDS-1:0] ONE    = N_LEDS'(1);
    localparam logic [N_LEDS-1:0] PAT_L  = ~(ALL >> WIN_LEDS);
    localparam logic [N_LEDS-1:0] PAT_R  = ~(ALL << WIN_LEDS);

    typedef enum logic [3:0] {
        S_RST, S_DARK, S_PLAY, S_SHOW, S_BLANK, S_SHOW2,
        S_WIN, S_WBLANK, S_WIN2, S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   pos_q, pos_d;
    logic [SW-1:0]   score_l_q, score_l_d, score_r_q, score_r_d;
    logic            win_left_q, win_left_d;
    logic            armed_q, armed_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      btn_q, btn_d;   // {left, right} level seen by the edge detector
    logic [1:0]      rise;
    logic            expired;
    logic [N_LEDS-1:0] led;

`ifdef TOW_SYNC_EN
    logic [1:0] sync1_q, sync1_d, sync2_q, sync2_d;
    assign sync1_d = {bus.pbl, bus.pbr};
    assign sync2_d = sync1_q;

    // Two-flop synchroniser per button ahead of edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end
    assign btn_d = sync2_q;
`else
    assign btn_d = {bus.pbl, bus.pbr};
`endif

    assign rise    = btn_d & ~btn_q;
    assign expired = (cnt_q == '0);

    // Next-state, position, score, arming and interval counter
    always_comb begin
        state_d    = state_q;
        pos_d      = pos_q;
        score_l_d  = score_l_q;
        score_r_d  = score_r_q;
        win_left_d = win_left_q;
        armed_d    = armed_q;
        if (btn_d == 2'b00) armed_d = 1'b1;
        case (state_q)
            S_RST:    state_d = S_DARK;
            S_DARK:   if (expired) state_d = S_PLAY;
            S_PLAY: begin
                if (armed_q && (rise != 2'b00)) begin
                    // any edge while armed disarms; a same-cycle tie moves nothing
                    armed_d = 1'b0;
                    if (rise == 2'b10) begin
                        if (pos_q == TOP) begin
                            win_left_d = 1'b1;
                            state_d    = S_WIN;
                            if (score_l_q < RMAX) score_l_d = score_l_q + SW'(1);
                        end else begin
                            pos_d   = pos_q + PW'(1);
                            state_d = S_SHOW;
                        end
                    end else if (rise == 2'b01) begin
                        if (pos_q == '0) begin
                            win_left_d = 1'b0;
                            state_d    = S_WIN;
                            if (score_r_q < RMAX) score_r_d = score_r_q + SW'(1);
                        end else begin
                            pos_d   = pos_q - PW'(1);
                            state_d = S_SHOW;
                        end
                    end
                end
            end
            S_SHOW:   if (expired) state_d = S_BLANK;
            S_BLANK:  if (expired) state_d = S_SHOW2;
            S_SHOW2:  if (expired) state_d = S_PLAY;
            S_WIN:    if (expired) state_d = S_WBLANK;
            S_WBLANK: if (expired) state_d = S_WIN2;
            S_WIN2: begin
                if (expired) begin
                    if ((win_left_q ? score_l_q : score_r_q) < RMAX) begin
                        pos_d   = CENTRE;
                        state_d = S_DARK;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            default:  state_d = state_q;
        endcase

        // one shared counter, reloaded whenever a new state is entered
        cnt_d = expired ? cnt_q : cnt_q - CW'(1);
        if (state_d != state_q) begin
            case (state_d)
                S_DARK, S_BLANK, S_WBLANK:      cnt_d = CW'(DARK_CYCLES - 1);
                S_SHOW, S_SHOW2, S_WIN, S_WIN2: cnt_d = CW'(SHOW_CYCLES - 1);
                default:                        cnt_d = '0;
            endcase
        end
    end

    // LED bar decode from state
    always_comb begin
        led = '0;
        case (state_q)
            S_RST:                    led = ALL;
            S_PLAY, S_SHOW, S_SHOW2:  led = ONE << pos_q;
            S_WIN, S_WIN2, S_DONE:    led = win_left_q ? PAT_L : PAT_R;
            default:                  led = '0;
        endcase
    end

    assign bus.led_out    = led;
    assign bus.score_l    = score_l_q;
    assign bus.score_r    = score_r_q;
    assign bus.match_over = (score_l_q == RMAX) || (score_r_q == RMAX);

    // State registers; buttons held through reset stay disarmed
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_RST;
            pos_q      <= CENTRE;
            score_l_q  <= '0;
            score_r_q  <= '0;
            win_left_q <= 1'b0;
            armed_q    <= 1'b0;
            cnt_q      <= '0;
            btn_q      <= '0;
        end else begin
            state_q    <= state_d;
            pos_q      <= pos_d;
            score_l_q  <= score_l_d;
            score_r_q  <= score_r_d;
            win_left_q <= win_left_d;
            armed_q    <= armed_d;
            cnt_q      <= cnt_d;
            btn_q      <= btn_d;
        end
    end
endmodule

// File: tb/tb_tow_param.sv
// tb_tow_param: directed and random button sequences against a game-rule model.
module tb_tow_param;
    localparam int N   = 7;
    localparam int WIN = 3;
    localparam int D   = 4;
    localparam int S   = 8;
    localparam int R   = 2;
    localparam int C   = (N - 1) / 2;
`ifdef TOW_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    tow_param_if #(.N_LEDS(N), .ROUNDS_TO_WIN(R)) bus ();

    tow_param #(.N_LEDS(N), .WIN_LEDS(WIN), .DARK_CYCLES(D), .SHOW_CYCLES(S),
                .ROUNDS_TO_WIN(R)) dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // game model: position, scores, match state
    int         mpos, msl, msr;
    bit         mdone, mwl;
    bit [1:0]   btnq[$];
    logic [N-1:0] expq[$];

    function automatic logic [N-1:0] pat(input bit left);
        int lo;
        lo = (1 << WIN) - 1;
        return left ? N'(lo << (N - WIN)) : N'(lo);
    endfunction

    function automatic logic [N-1:0] cur();
        return mdone ? pat(mwl) : N'(1 << mpos);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_status(input string tag);
        chk({tag, "_score_l"}, 64'(bus.score_l), 64'(msl));
        chk({tag, "_score_r"}, 64'(bus.score_r), 64'(msr));
        chk({tag, "_match_over"}, 64'(bus.match_over), 64'(mdone));
    endtask

    // append the LED trace produced by one accepted push
    task automatic model_push(input bit left);
        logic [N-1:0] p;
        if (mdone) return;
        if ((left && mpos == N - 1) || (!left && mpos == 0)) begin
            if (left) msl = (msl < R) ? msl + 1 : R;
            else      msr = (msr < R) ? msr + 1 : R;
            mwl = left;
            p = pat(left);
            repeat (S) expq.push_back(p);
            repeat (D) expq.push_back('0);
            repeat (S) expq.push_back(p);
            if ((left ? msl : msr) >= R) mdone = 1'b1;
            else begin
                mpos = C;
                repeat (D) expq.push_back('0);
            end
        end else begin
            mpos = left ? mpos + 1 : mpos - 1;
            p = N'(1 << mpos);
            repeat (S) expq.push_back(p);
            repeat (D) expq.push_back('0);
            repeat (S) expq.push_back(p);
        end
    endtask

    task automatic run_q(input string tag);
        int n;
        n = (btnq.size() > expq.size()) ? btnq.size() : expq.size();
        for (int i = 0; i < n; i++) begin
            {bus.pbl, bus.pbr} = (i < btnq.size()) ? btnq[i] : 2'b00;
            tick();
            if (i < expq.size())
                chk($sformatf("%s_led%0d", tag, i), 64'(bus.led_out), 64'(expq[i]));
        end
        {bus.pbl, bus.pbr} = 2'b00;
    endtask

    // kind: 0 left, 1 right, 2 tie, 3 left then right, 4 right then left
    task automatic act(input int kind, input int gap, input string tag);
        btnq.delete();
        expq.delete();
        for (int i = 0; i < gap; i++) begin
            btnq.push_back(2'b00);
            expq.push_back(cur());
        end
        case (kind)
            0: btnq.push_back(2'b10);
            1: btnq.push_back(2'b01);
            2: btnq.push_back(2'b11);
            3: begin btnq.push_back(2'b10); btnq.push_back(2'b11); end
            default: begin btnq.push_back(2'b01); btnq.push_back(2'b11); end
        endcase
        for (int i = 0; i < LAT; i++) expq.push_back(cur());
        if (kind == 0 || kind == 3) model_push(1'b1);
        else if (kind == 1 || kind == 4) model_push(1'b0);
        repeat (3) expq.push_back(cur());
        run_q(tag);
        chk_status(tag);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        {bus.pbl, bus.pbr} = 2'b00;
        #1 rst = 1'b0;
        #2;
        chk({tag, "_rst_led"}, 64'(bus.led_out), 64'({N{1'b1}}));
        mpos = C; msl = 0; msr = 0; mdone = 1'b0; mwl = 1'b0;
        chk_status({tag, "_rst"});
        tick();
        tick();
        chk({tag, "_rst_hold"}, 64'(bus.led_out), 64'({N{1'b1}}));
        rst = 1'b1;
        btnq.delete();
        expq.delete();
        repeat (D) expq.push_back('0);
        repeat (2) expq.push_back(cur());
        run_q({tag, "_boot"});
    endtask

    initial begin
        int g;
        rst = 1'b1;
        bus.pbl = 1'b0;
        bus.pbr = 1'b0;

        do_reset("r0");

        // single left moves
        act(0, 1 + LAT, "left1");
        act(0, 1 + LAT, "left2");
        // left then right a cycle later: left only
        act(3, 1 + LAT, "l_then_r");
        // tie: nothing moves
        act(2, 1 + LAT, "tie");
        act(1, 1 + LAT, "right_after_tie");

        // left held through whole sequence, then right pressed: ignored
        btnq.delete();
        expq.delete();
        for (int i = 0; i < LAT; i++) expq.push_back(cur());
        model_push(1'b1);
        g = expq.size() + 2;
        repeat (g) btnq.push_back(2'b10);
        repeat (3) btnq.push_back(2'b11);
        while (expq.size() < btnq.size() + LAT + 2) expq.push_back(cur());
        run_q("held");
        act(1, 1 + LAT, "after_held");

        // left round win, then match win
        g = 0;
        while (msl == 0 && g < 20) begin act(0, 1 + LAT, "to_win1"); g++; end
        g = 0;
        while (!mdone && g < 20) begin act(0, 1 + LAT, "to_win2"); g++; end
        act(0, 1 + LAT, "done_l");
        act(1, 2 + LAT, "done_r");

        // random play on a fresh match
        do_reset("r1");
        for (int k = 0; k < 60; k++)
            act(int'($urandom_range(0, 4)), 1 + LAT + int'($urandom_range(0, 2)), "rnd");

        // right round win, then reset mid-SHOW
        do_reset("r2");
        g = 0;
        while (msr == 0 && g < 20) begin act(1, 1 + LAT, "to_rwin"); g++; end
        bus.pbr = 1'b1;
        tick();
        bus.pbr = 1'b0;
        repeat (LAT + 3) tick();
        chk("mid_show_led", 64'(bus.led_out), 64'(N'(1 << (C - 1))));
        rst = 1'b0;
        #2;
        chk("mid_rst_led", 64'(bus.led_out), 64'({N{1'b1}}));
        chk("mid_rst_score_r", 64'(bus.score_r), 64'(0));
        chk("mid_rst_match", 64'(bus.match_over), 64'(0));
        tick();
        rst = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
